// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC register, per-cycle fetch into a small FIFO, valid/ready to decode.
// Latency: start -> first instruction valid 2 cycles later; redirect -> new stream valid 2 cycles later.
// Backpressure: a full FIFO without a pop stalls fetch and holds the PC; push+pop together keeps one per cycle.
module fetch_controller #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int RESET_PC    = 0,
    parameter int PC_STEP     = 4,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   halt_i,
    input  logic                   redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
    output logic [ADDR_WIDTH-1:0]  mem_address_o,
    input  logic [INSTR_WIDTH-1:0] mem_instruction_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    input  logic                   instr_ready_i,
    output logic                   busy_o,
    output logic                   halted_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    entry_t                fifo_q [FIFO_DEPTH];
    entry_t                fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic pop;
    logic push;
    logic full;

    always_comb begin
        full = (count_q == CNT_W'(FIFO_DEPTH));
        pop  = (count_q != '0) && instr_ready_i && !redirect_valid_i;
        // The halt cycle itself never fetches, so the PC stays on the next unfetched address.
        push = (state_q == RUN) && !redirect_valid_i && !halt_i && (!full || pop);

        state_d = state_q;
        if (halt_i) begin
            if (state_q == RUN) state_d = HALTED;
        end else if (start_i) begin
            if (state_q == IDLE || state_q == HALTED) state_d = RUN;
        end

        fetch_pc_d = fetch_pc_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_i;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = '{pc: fetch_pc_q, instr: mem_instruction_i};
                wr_ptr_d         = wr_ptr_q + 1'b1;
                fetch_pc_d       = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end

    assign mem_address_o = fetch_pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = fifo_q[rd_ptr_q].instr;
    assign instr_pc_o    = fifo_q[rd_ptr_q].pc;
    assign busy_o        = (state_q == RUN) || (count_q != '0);
    assign halted_o      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a queue-based reference of the fetch stream.
module tb_fetch_controller;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, halt_i, redirect_valid_i, instr_ready_i;
    logic [7:0]  redirect_pc_i;
    logic [7:0]  mem_address_o;
    logic [31:0] mem_instruction_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [7:0]  instr_pc_o;
    logic        busy_o, halted_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_controller #(
        .ADDR_WIDTH(8), .INSTR_WIDTH(32), .RESET_PC(0), .PC_STEP(4), .FIFO_DEPTH(2)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .mem_address_o(mem_address_o), .mem_instruction_i(mem_instruction_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .busy_o(busy_o), .halted_o(halted_o)
    );

    always #5 clk_i = ~clk_i;

    // Byte-addressed program memory, little-endian word read.
    logic [7:0] mem [256];
    logic [7:0] a1, a2, a3;
    assign a1 = mem_address_o + 8'd1;
    assign a2 = mem_address_o + 8'd2;
    assign a3 = mem_address_o + 8'd3;
    assign mem_instruction_i = {mem[a3], mem[a2], mem[a1], mem[mem_address_o]};

    // Reference model: fetch state as a name, buffered stream as a queue.
    localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2;
    int          m_state;
    logic [7:0]  m_pc;
    logic [39:0] m_q [$];

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] b1, b2, b3;
        b1 = a + 8'd1; b2 = a + 8'd2; b3 = a + 8'd3;
        return {mem[b3], mem[b2], mem[b1], mem[a]};
    endfunction

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_pc    = 8'd0;
        m_q.delete();
    endtask

    task automatic check_outputs();
        logic [39:0] head;
        chk("mem_address", 40'(mem_address_o), 40'(m_pc));
        chk("instr_valid", 40'(instr_valid_o), 40'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            head = m_q[0];
            chk("instr_pc", 40'(instr_pc_o), 40'(head[39:32]));
            chk("instr", 40'(instr_o), 40'(head[31:0]));
        end
        chk("busy", 40'(busy_o), 40'(m_state == S_RUN || m_q.size() != 0));
        chk("halted", 40'(halted_o), 40'(m_state == S_HALTED));
    endtask

    task automatic model_step(input logic st, input logic ht, input logic rd,
                              input logic [7:0] rpc, input logic rdy);
        bit do_pop, do_push;
        int nxt;
        do_pop  = (m_q.size() != 0) && rdy && !rd;
        do_push = (m_state == S_RUN) && !rd && !ht && (m_q.size() < 2 || do_pop);
        nxt = m_state;
        if (ht) begin
            if (m_state == S_RUN) nxt = S_HALTED;
        end else if (st && m_state != S_RUN) begin
            nxt = S_RUN;
        end
        if (rd) begin
            m_q.delete();
            m_pc = rpc;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back({m_pc, word_at(m_pc)});
                m_pc = m_pc + 8'd4;
            end
        end
        m_state = nxt;
    endtask

    // One cycle: called at a falling edge, returns at the next falling edge.
    task automatic cyc(input logic st, input logic ht, input logic rd,
                       input logic [7:0] rpc, input logic rdy);
        check_outputs();
        start_i = st; halt_i = ht; redirect_valid_i = rd; redirect_pc_i = rpc; instr_ready_i = rdy;
        model_step(st, ht, rd, rpc, rdy);
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 40'(instr_valid_o), 40'd0);
        chk({tag, "_instr"}, 40'(instr_o), 40'd0);
        chk({tag, "_pc"}, 40'(instr_pc_o), 40'd0);
        chk({tag, "_busy"}, 40'(busy_o), 40'd0);
        chk({tag, "_halted"}, 40'(halted_o), 40'd0);
        chk({tag, "_addr"}, 40'(mem_address_o), 40'd0);
    endtask

    // Reset asserted between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        check_outputs();
        start_i = 0; halt_i = 0; redirect_valid_i = 0; instr_ready_i = 0;
        #2 rst_i = 1'b1;
        #1 check_reset_values("async_rst");
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rst_i = 1'b1;
        start_i = 0; halt_i = 0; redirect_valid_i = 0; redirect_pc_i = 0; instr_ready_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_reset_values("reset");
        rst_i = 1'b0;

        // Streaming from reset
        cyc(1, 0, 0, 8'h00, 1);
        repeat (6) cyc(0, 0, 0, 8'h00, 1);
        // Backpressure then release
        repeat (5) cyc(0, 0, 0, 8'h00, 0);
        repeat (5) cyc(0, 0, 0, 8'h00, 1);
        // Redirect with FIFO full and ready high
        repeat (3) cyc(0, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h40, 1);
        repeat (4) cyc(0, 0, 0, 8'h00, 1);
        // Halt with fetch_pc at 0x10, drain, resume
        cyc(0, 0, 1, 8'h0C, 0);
        cyc(0, 0, 0, 8'h00, 0);
        chk("pc_before_halt", 40'(mem_address_o), 40'h10);
        cyc(0, 1, 0, 8'h00, 0);
        repeat (4) cyc(0, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 1);
        repeat (4) cyc(0, 0, 0, 8'h00, 1);
        // Wrap past the top of the address space
        cyc(0, 0, 1, 8'hF8, 1);
        repeat (5) cyc(0, 0, 0, 8'h00, 1);
        // Async reset mid-stream, then start+halt in IDLE, then restart
        async_reset();
        cyc(1, 1, 0, 8'h00, 1);
        repeat (3) cyc(0, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 1);
        repeat (5) cyc(0, 0, 0, 8'h00, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 19) == 0), 8'($urandom),
                    1'($urandom_range(0, 9) < 7));
            end
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
